// File: rtl/kd_tree_query_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : kd_tree_query_scheduler
// Description : Loads the KD-tree internal nodes, then streams query patch
//               pairs into the fixed-latency tree under result-FIFO credits.
// Revision    : 1.0 - initial release
// ============================================================================
module kd_tree_query_scheduler #(
    parameter int INTERNAL_WIDTH = 22,
    parameter int PATCH_WIDTH    = 55,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int NUM_NODES      = 63,
    parameter int TREE_LATENCY   = 6,
    parameter int RESULT_DEPTH   = 8,
    parameter int QCNT_WIDTH     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [QCNT_WIDTH-1:0]     num_queries,
    input  logic                      wb_mode,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    input  logic                      node_valid,
    output logic                      node_ready,
    input  logic [INTERNAL_WIDTH-1:0] node_data,
    input  logic                      patch_valid,
    output logic                      patch_ready,
    input  logic                      patch_b_valid,
    input  logic [PATCH_WIDTH-1:0]    patch_a,
    input  logic [PATCH_WIDTH-1:0]    patch_b,
    output logic                      fsm_enable,
    output logic                      sender_enable,
    output logic [INTERNAL_WIDTH-1:0] sender_data,
    output logic                      patch_en,
    output logic                      patch_two_en,
    output logic [PATCH_WIDTH-1:0]    patch_in,
    output logic [PATCH_WIDTH-1:0]    patch_in_two,
    input  logic [ADDRESS_WIDTH-1:0]  leaf_index,
    input  logic [ADDRESS_WIDTH-1:0]  leaf_index_two,
    input  logic                      receiver_en,
    input  logic                      receiver_two_en,
    output logic                      result_valid,
    input  logic                      result_ready,
    output logic [ADDRESS_WIDTH-1:0]  result_index_a,
    output logic [ADDRESS_WIDTH-1:0]  result_index_b,
    output logic                      result_b_valid
);

    localparam int c_NODE_W = $clog2(NUM_NODES + 1);
    localparam int c_CNT_W  = $clog2(RESULT_DEPTH + 1);
    localparam int c_PTR_W  = $clog2(RESULT_DEPTH);
    localparam int c_ENT_W  = 2 * ADDRESS_WIDTH + 1;

    if (TREE_LATENCY < 1 || RESULT_DEPTH < 2 || (RESULT_DEPTH & (RESULT_DEPTH - 1)) != 0) begin : g_param_check
        $error("kd_tree_query_scheduler: illegal TREE_LATENCY or RESULT_DEPTH");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_QUERY = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_NODE_W-1:0]   r_node_cnt;
    logic [QCNT_WIDTH-1:0] r_num_q;
    logic [QCNT_WIDTH-1:0] r_issued;
    logic [c_CNT_W-1:0]    r_inflight;
    logic [c_CNT_W-1:0]    r_fifo_count;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic                  r_error;
    logic [c_ENT_W-1:0]    r_mem [RESULT_DEPTH];

    logic                  w_start;
    logic                  w_node_acc;
    logic                  w_patch_acc;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_has_credit;
    logic [c_CNT_W:0]      w_used;
    logic [c_ENT_W-1:0]    w_head;

    assign w_start      = (r_state == S_IDLE) && start && !wb_mode;
    assign w_used       = {1'b0, r_fifo_count} + {1'b0, r_inflight};
    assign w_has_credit = w_used < (c_CNT_W + 1)'(RESULT_DEPTH);
    assign w_node_acc   = (r_state == S_LOAD) && !wb_mode && node_valid;
    assign w_patch_acc  = patch_ready && patch_valid;
    // A result that arrives with nothing in flight cannot be ours; drop it.
    assign w_push       = receiver_en && (r_inflight != '0);
    assign w_pop        = (r_fifo_count != '0) && result_ready;
    assign w_head       = r_mem[r_rd_ptr];

    always_comb begin
        w_state_nxt   = r_state;
        busy          = (r_state != S_IDLE);
        done          = 1'b0;
        fsm_enable    = 1'b0;
        node_ready    = 1'b0;
        sender_enable = 1'b0;
        sender_data   = '0;
        patch_ready   = 1'b0;
        patch_en      = 1'b0;
        patch_two_en  = 1'b0;
        patch_in      = '0;
        patch_in_two  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                fsm_enable    = 1'b1;
                node_ready    = !wb_mode;
                sender_enable = w_node_acc;
                sender_data   = node_data;
                if (w_node_acc && r_node_cnt == c_NODE_W'(NUM_NODES - 1))
                    w_state_nxt = (r_num_q == '0) ? S_DRAIN : S_QUERY;
            end
            S_QUERY: begin
                patch_ready  = !wb_mode && w_has_credit && (r_issued < r_num_q);
                patch_en     = patch_ready && patch_valid;
                patch_two_en = patch_ready && patch_valid && patch_b_valid;
                patch_in     = patch_a;
                patch_in_two = patch_b;
                if (patch_ready && patch_valid && r_issued == r_num_q - QCNT_WIDTH'(1))
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_inflight == '0 && r_fifo_count == '0) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_node_cnt   <= '0;
            r_num_q      <= '0;
            r_issued     <= '0;
            r_inflight   <= '0;
            r_fifo_count <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_error      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_node_cnt <= '0;
                r_issued   <= '0;
                r_num_q    <= num_queries;
            end else begin
                if (w_node_acc)  r_node_cnt <= r_node_cnt + c_NODE_W'(1);
                if (w_patch_acc) r_issued   <= r_issued + QCNT_WIDTH'(1);
            end
            case ({w_patch_acc, w_push})
                2'b10:   r_inflight <= r_inflight + c_CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - c_CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
            if (receiver_en && r_inflight == '0) r_error <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + c_CNT_W'(1);
                2'b01:   r_fifo_count <= r_fifo_count - c_CNT_W'(1);
                default: r_fifo_count <= r_fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {leaf_index, leaf_index_two, receiver_two_en};
    end

    // Credits make a write into a full FIFO impossible.
    always_ff @(posedge clk) begin
        if (!rst) assert (!(w_push && r_fifo_count == c_CNT_W'(RESULT_DEPTH)));
    end

    assign error          = r_error;
    assign result_valid   = (r_fifo_count != '0);
    assign result_index_a = result_valid ? w_head[c_ENT_W-1 -: ADDRESS_WIDTH] : '0;
    assign result_index_b = result_valid ? w_head[ADDRESS_WIDTH:1] : '0;
    assign result_b_valid = result_valid && w_head[0];

endmodule
`default_nettype wire

// File: tb/tb_kd_tree_query_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_kd_tree_query_scheduler
// Description : Directed bench with a 6-stage tree model and result tables.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kd_tree_query_scheduler;

    localparam int IW = 22;
    localparam int PW = 55;
    localparam int AW = 8;
    localparam int NN = 63;
    localparam int TL = 6;
    localparam int RD = 8;
    localparam int QW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [QW-1:0] num_queries = '0;
    logic          wb_mode = 1'b0;
    logic          node_valid = 1'b1;
    logic          result_ready = 1'b0;
    logic          force_rx = 1'b0;
    logic          run_p = 1'b0;
    logic          busy, done, error, node_ready, patch_valid, patch_ready, patch_b_valid;
    logic          fsm_enable, sender_enable, patch_en, patch_two_en;
    logic          receiver_en, receiver_two_en, result_valid, result_b_valid;
    logic [IW-1:0] node_data, sender_data;
    logic [PW-1:0] patch_a, patch_b, patch_in, patch_in_two;
    logic [AW-1:0] leaf_index, leaf_index_two, result_index_a, result_index_b;

    int n_err = 0, n_chk = 0;
    int nidx = 0, nbase = 0, pidx = 0, pbase = 0, npatch = 0, ridx = 0, rbase = 0, cyc = 0;
    int se_cnt = 0, se_wb = 0, fe_cnt = 0, acc_cyc = 0, rv_rise = 0;
    logic prev_rv = 1'b0;
    logic [7:0] tab_a [32];
    logic [7:0] tab_b [32];
    logic       tab_bv [32];
    logic       pt_en [32];
    logic       pv [TL];
    logic       pv2 [TL];
    logic [7:0] pa [TL];
    logic [7:0] pb [TL];

    kd_tree_query_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .num_queries(num_queries), .wb_mode(wb_mode),
        .busy(busy), .done(done), .error(error),
        .node_valid(node_valid), .node_ready(node_ready), .node_data(node_data),
        .patch_valid(patch_valid), .patch_ready(patch_ready), .patch_b_valid(patch_b_valid),
        .patch_a(patch_a), .patch_b(patch_b),
        .fsm_enable(fsm_enable), .sender_enable(sender_enable), .sender_data(sender_data),
        .patch_en(patch_en), .patch_two_en(patch_two_en), .patch_in(patch_in), .patch_in_two(patch_in_two),
        .leaf_index(leaf_index), .leaf_index_two(leaf_index_two),
        .receiver_en(receiver_en), .receiver_two_en(receiver_two_en),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_index_a(result_index_a), .result_index_b(result_index_b), .result_b_valid(result_b_valid)
    );

    always #5 clk = ~clk;

    assign node_data     = IW'(nidx - nbase);
    assign patch_valid   = run_p && ((pidx - pbase) < npatch);
    assign patch_a       = {47'(pidx), tab_a[pidx - pbase]};
    assign patch_b       = {47'(pidx + 1000), tab_b[pidx - pbase]};
    assign patch_b_valid = tab_bv[pidx - pbase];

    // Tree model: leaf index = low byte of the patch, TL cycles later.
    assign receiver_en     = pv[TL-1] | force_rx;
    assign receiver_two_en = pv2[TL-1];
    assign leaf_index      = pa[TL-1];
    assign leaf_index_two  = pb[TL-1];

    always @(posedge clk) begin
        pv[0]  <= patch_en;
        pv2[0] <= patch_two_en;
        pa[0]  <= patch_in[7:0];
        pb[0]  <= patch_in_two[7:0];
        for (int k = 1; k < TL; k++) begin
            pv[k]  <= pv[k-1];
            pv2[k] <= pv2[k-1];
            pa[k]  <= pa[k-1];
            pb[k]  <= pb[k-1];
        end
        if (node_valid && node_ready) nidx <= nidx + 1;
        if (patch_valid && patch_ready) pidx <= pidx + 1;
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sender_enable) begin
            check("sender_data", 64'(sender_data), 64'(nidx - nbase));
            se_cnt++;
            if (wb_mode) se_wb++;
        end
        if (fsm_enable) fe_cnt++;
        if (patch_en) begin
            pt_en[pidx - pbase] = patch_two_en;
            acc_cyc = cyc;
        end
        if (result_valid && !prev_rv) rv_rise = cyc;
        prev_rv = result_valid;
        if (result_valid && result_ready) begin
            check("res_a",  64'(result_index_a), 64'(tab_a[ridx - rbase]));
            check("res_b",  64'(result_index_b), 64'(tab_b[ridx - rbase]));
            check("res_bv", 64'(result_b_valid), 64'(tab_bv[ridx - rbase]));
            ridx++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int nq);
        nbase = nidx;
        pbase = pidx;
        rbase = ridx;
        num_queries = QW'(nq);
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lim);
        logic seen = 1'b0;
        for (int k = 0; k < lim && !seen; k++) begin
            @(negedge clk);
            seen = done;
        end
        check(tag, 64'(seen), 64'd1);
        tick(1);
    endtask

    initial begin
        for (int k = 0; k < TL; k++) begin
            pv[k] = 1'b0; pv2[k] = 1'b0; pa[k] = '0; pb[k] = '0;
        end
        for (int k = 0; k < 32; k++) begin
            tab_a[k] = 8'(10 + k); tab_b[k] = 8'(100 + k); tab_bv[k] = 1'b1; pt_en[k] = 1'b0;
        end
        tick(2);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_rvalid", 64'(result_valid), 64'd0);
        check("rst_node_ready", 64'(node_ready), 64'd0);
        check("rst_fsm_enable", 64'(fsm_enable), 64'd0);
        rst = 1'b0;
        tick(2);

        begin : t_load_only
            int se0, fe0;
            se0 = se_cnt; fe0 = fe_cnt;
            do_start(0);
            wait_done("load_done", 200);
            check("load_writes", 64'(se_cnt - se0), 64'd63);
            check("load_fsm_en", 64'(fe_cnt - fe0), 64'd63);
            check("load_words", 64'(nidx - nbase), 64'd63);
            check("load_idle", 64'(busy), 64'd0);
        end

        begin : t_single
            tab_a[0] = 8'd5; tab_b[0] = 8'd9; tab_bv[0] = 1'b1;
            npatch = 1; result_ready = 1'b1; run_p = 1'b1;
            do_start(1);
            wait_done("single_done", 300);
            check("single_latency", 64'(rv_rise - acc_cyc), 64'd7);
            check("single_count", 64'(ridx - rbase), 64'd1);
            run_p = 1'b0;
        end

        begin : t_backpressure
            for (int k = 0; k < 20; k++) begin
                tab_a[k] = 8'(10 + k); tab_b[k] = 8'(100 + k); tab_bv[k] = 1'b1;
            end
            npatch = 20; result_ready = 1'b0; run_p = 1'b1;
            do_start(20);
            tick(120);
            check("bp_accepts", 64'(pidx - pbase), 64'd8);
            check("bp_ready_low", 64'(patch_ready), 64'd0);
            check("bp_rvalid", 64'(result_valid), 64'd1);
            result_ready = 1'b1;
            wait_done("bp_done", 400);
            check("bp_results", 64'(ridx - rbase), 64'd20);
            check("bp_error", 64'(error), 64'd0);
            run_p = 1'b0;
        end

        begin : t_odd_tail
            tab_a[0] = 8'd3; tab_b[0] = 8'd30; tab_bv[0] = 1'b1;
            tab_a[1] = 8'd4; tab_b[1] = 8'd40; tab_bv[1] = 1'b1;
            tab_a[2] = 8'd5; tab_b[2] = 8'd50; tab_bv[2] = 1'b0;
            npatch = 3; run_p = 1'b1;
            do_start(3);
            wait_done("odd_done", 300);
            check("odd_two_en0", 64'(pt_en[0]), 64'd1);
            check("odd_two_en2", 64'(pt_en[2]), 64'd0);
            check("odd_results", 64'(ridx - rbase), 64'd3);
            run_p = 1'b0;
            tab_bv[2] = 1'b1;
        end

        begin : t_wb_pause
            int se0, wb0, k;
            se0 = se_cnt; wb0 = se_wb; k = 0;
            do_start(0);
            while ((nidx - nbase) < 30 && k < 200) begin
                tick(1);
                k++;
            end
            check("wb_reached30", 64'(nidx - nbase), 64'd30);
            wb_mode = 1'b1;
            tick(10);
            check("wb_held", 64'(nidx - nbase), 64'd30);
            wb_mode = 1'b0;
            wait_done("wb_done", 200);
            check("wb_no_writes", 64'(se_wb - wb0), 64'd0);
            check("wb_writes", 64'(se_cnt - se0), 64'd63);
        end

        begin : t_spurious
            force_rx = 1'b1;
            tick(1);
            force_rx = 1'b0;
            check("spur_error", 64'(error), 64'd1);
            check("spur_rvalid", 64'(result_valid), 64'd0);
            tick(2);
            check("spur_rvalid_late", 64'(result_valid), 64'd0);
        end

        begin : t_reset_mid
            int k;
            k = 0;
            npatch = 20; result_ready = 1'b0; run_p = 1'b1;
            do_start(20);
            while ((pidx - pbase) < 3 && k < 200) begin
                tick(1);
                k++;
            end
            #2;
            rst = 1'b1;
            #1;
            check("mid_rst_busy", 64'(busy), 64'd0);
            check("mid_rst_patch_en", 64'(patch_en), 64'd0);
            check("mid_rst_patch_ready", 64'(patch_ready), 64'd0);
            check("mid_rst_error", 64'(error), 64'd0);
            check("mid_rst_rvalid", 64'(result_valid), 64'd0);
            check("mid_rst_index_a", 64'(result_index_a), 64'd0);
            run_p = 1'b0;
            @(posedge clk);
            #1;
            rst = 1'b0;
            tick(10);
            check("stale_error", 64'(error), 64'd1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
